// File: rtl/soc_msp430_ram_sp_gen.sv
// rtl/soc_msp430_ram_sp_gen.sv - parametrised single-port RAM with byte lanes, output pipe and clear sweep
//
// Ports:
//   ram_clk       clock, rising edge
//   ram_rst       synchronous active-high reset
//   ram_addr      word address
//   ram_cen       chip enable, active-low
//   ram_wen       per-byte write enable, active-low
//   ram_din       write data
//   ram_dout      read data, held until the next delivered result
//   ram_dout_vld  one-cycle strobe per accepted access
//   ram_busy      clear sweep in progress; accesses ignored
module soc_msp430_ram_sp_gen #(
  parameter int ADDR_MSB       = 6,
  parameter int MEM_SIZE       = 256,
  parameter int DATA_WIDTH     = 16,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    ram_clk,
  input  logic                    ram_rst,
  input  logic [ADDR_MSB:0]       ram_addr,
  input  logic                    ram_cen,
  input  logic [DATA_WIDTH/8-1:0] ram_wen,
  input  logic [DATA_WIDTH-1:0]   ram_din,
  output logic [DATA_WIDTH-1:0]   ram_dout,
  output logic                    ram_dout_vld,
  output logic                    ram_busy
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int DEPTH = MEM_SIZE / LANES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_RESET_HOLD = 2'd0;
  localparam logic [1:0] ST_CLEAR      = 2'd1;
  localparam logic [1:0] ST_IDLE       = 2'd2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;

  // Request stage: the accepted access is registered first, the array is
  // touched on the following edge.
  logic                  req_vld_q, req_vld_d;
  logic [ADDR_MSB:0]     req_addr_q, req_addr_d;
  logic [LANES-1:0]      req_wen_q, req_wen_d;
  logic [DATA_WIDTH-1:0] req_din_q, req_din_d;

  logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
  logic                  vld1_q, vld1_d;
  logic [DATA_WIDTH-1:0] dout2_q, dout2_d;
  logic                  vld2_q, vld2_d;

  logic                  acc;
  logic [31:0]           addr_ext;
  logic                  in_range;
  logic [AW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  mem_we;
  logic [AW-1:0]         mem_idx;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign ram_busy = (state_q == ST_CLEAR) ||
                    ((state_q == ST_RESET_HOLD) && (CLEAR_ON_RESET != 0));
  assign acc      = !ram_cen && !ram_busy && !ram_rst;

  // Clear sweep FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESET_HOLD: begin
        cnt_d   = '0;
        state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: ;
      default: state_d = ST_RESET_HOLD;
    endcase
  end

  always_comb begin
    req_vld_d  = acc;
    req_addr_d = acc ? ram_addr : req_addr_q;
    req_wen_d  = acc ? ram_wen  : req_wen_q;
    req_din_d  = acc ? ram_din  : req_din_q;
  end

  // Write-first merge: returned word is the stored word with written lanes replaced.
  always_comb begin
    addr_ext = 32'(req_addr_q);
    in_range = addr_ext < 32'(DEPTH);
    rd_idx   = addr_ext[AW-1:0];
    merged   = mem[rd_idx];
    for (int i = 0; i < LANES; i++) begin
      if (!req_wen_q[i]) merged[8*i +: 8] = req_din_q[8*i +: 8];
    end
    rd_word  = in_range ? merged : '0;
  end

  // Single write port shared by the sweep and normal writes; they never overlap
  // because requests are only accepted outside the sweep.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = rd_idx;
    mem_wdata = merged;
    if (!ram_rst) begin
      if (state_q == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_idx   = cnt_q;
        mem_wdata = '0;
      end else if (req_vld_q && in_range && !(&req_wen_q)) begin
        mem_we    = 1'b1;
      end
    end
  end

  always_comb begin
    vld1_d  = req_vld_q;
    dout1_d = req_vld_q ? rd_word : dout1_q;
    vld2_d  = vld1_q;
    dout2_d = vld1_q ? dout1_q : dout2_q;
  end

  always_ff @(posedge ram_clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      state_q    <= ST_RESET_HOLD;
      cnt_q      <= '0;
      req_vld_q  <= 1'b0;
      req_addr_q <= '0;
      req_wen_q  <= '1;
      req_din_q  <= '0;
      dout1_q    <= '0;
      vld1_q     <= 1'b0;
      dout2_q    <= '0;
      vld2_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_vld_q  <= req_vld_d;
      req_addr_q <= req_addr_d;
      req_wen_q  <= req_wen_d;
      req_din_q  <= req_din_d;
      dout1_q    <= dout1_d;
      vld1_q     <= vld1_d;
      dout2_q    <= dout2_d;
      vld2_q     <= vld2_d;
    end
  end

  assign ram_dout     = (OUT_REG != 0) ? dout2_q : dout1_q;
  assign ram_dout_vld = (OUT_REG != 0) ? vld2_q  : vld1_q;

endmodule

// File: tb/tb_soc_msp430_ram_sp_gen.sv
// tb/tb_soc_msp430_ram_sp_gen.sv - directed bench for soc_msp430_ram_sp_gen
module tb_soc_msp430_ram_sp_gen;

  logic        clk;
  logic        rst;
  logic [7:0]  addr;
  logic        cen;
  logic        blk2;
  logic [1:0]  wen;
  logic [15:0] din;

  logic [15:0] u0_dout, u1_dout, u2_dout;
  logic        u0_vld, u1_vld, u2_vld;
  logic        u0_busy, u1_busy, u2_busy;

  int n_tests = 0;
  int n_fail  = 0;

  soc_msp430_ram_sp_gen #(.ADDR_MSB(7), .MEM_SIZE(256), .DATA_WIDTH(16), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
    .ram_clk(clk), .ram_rst(rst), .ram_addr(addr), .ram_cen(cen), .ram_wen(wen), .ram_din(din),
    .ram_dout(u0_dout), .ram_dout_vld(u0_vld), .ram_busy(u0_busy));

  soc_msp430_ram_sp_gen #(.ADDR_MSB(7), .MEM_SIZE(256), .DATA_WIDTH(16), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
    .ram_clk(clk), .ram_rst(rst), .ram_addr(addr), .ram_cen(cen), .ram_wen(wen), .ram_din(din),
    .ram_dout(u1_dout), .ram_dout_vld(u1_vld), .ram_busy(u1_busy));

  soc_msp430_ram_sp_gen #(.ADDR_MSB(7), .MEM_SIZE(256), .DATA_WIDTH(16), .OUT_REG(0), .CLEAR_ON_RESET(0)) u2 (
    .ram_clk(clk), .ram_rst(rst), .ram_addr(addr), .ram_cen(cen | blk2), .ram_wen(wen), .ram_din(din),
    .ram_dout(u2_dout), .ram_dout_vld(u2_vld), .ram_busy(u2_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] a, input logic [1:0] w, input logic [15:0] d);
    addr = a; wen = w; din = d; cen = 1'b0;
    tick;
  endtask

  // One isolated access; checks both latencies and single-cycle strobes.
  task automatic xfer(input string tag, input logic [7:0] a, input logic [1:0] w,
                      input logic [15:0] d, input logic [15:0] exp);
    issue(a, w, d);
    cen = 1'b1; wen = 2'b11;
    tick;
    check({tag, "_u0_vld"}, 32'(u0_vld), 1);
    check({tag, "_u0_dout"}, 32'(u0_dout), 32'(exp));
    check({tag, "_u1_vld_early"}, 32'(u1_vld), 0);
    tick;
    check({tag, "_u0_vld_off"}, 32'(u0_vld), 0);
    check({tag, "_u0_hold"}, 32'(u0_dout), 32'(exp));
    check({tag, "_u1_vld"}, 32'(u1_vld), 1);
    check({tag, "_u1_dout"}, 32'(u1_dout), 32'(exp));
    tick;
    check({tag, "_u1_vld_off"}, 32'(u1_vld), 0);
  endtask

  // Call with rst already low; the first tick is the first edge with reset released.
  task automatic busy_window(output int n0, output int n1, output logic vs);
    n0 = 0; n1 = 0; vs = 1'b0;
    tick;
    for (int k = 0; k < 400; k++) begin
      if (!u0_busy && !u1_busy) break;
      if (u0_busy) n0++;
      if (u1_busy) n1++;
      vs = vs | u0_vld | u1_vld;
      tick;
    end
    cen = 1'b1; wen = 2'b11;
  endtask

  function automatic logic [15:0] exp_word(input int i);
    case (i)
      1: return 16'h0011;
      2: return 16'h0022;
      3: return 16'h0033;
      5: return 16'h12CC;
      default: return 16'h0000;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1;
    logic vs;

    rst = 1'b1; cen = 1'b1; blk2 = 1'b0; wen = 2'b11; din = '0; addr = '0;
    tick; tick; tick;
    check("rst_u0_dout", 32'(u0_dout), 0);
    check("rst_u0_vld", 32'(u0_vld), 0);
    check("rst_u0_busy", 32'(u0_busy), 1);
    check("rst_u1_dout", 32'(u1_dout), 0);
    check("rst_u1_vld", 32'(u1_vld), 0);
    check("rst_u2_busy", 32'(u2_busy), 0);

    rst = 1'b0;
    busy_window(n0, n1, vs);
    check("init_busy_u0", 32'(n0), 128);
    check("init_busy_u1", 32'(n1), 128);
    check("init_busy_vld", 32'(vs), 0);
    check("init_u2_busy", 32'(u2_busy), 0);

    // Full write then same-address read, back to back
    issue(8'd5, 2'b00, 16'hA55A);
    issue(8'd5, 2'b11, 16'h0000);
    check("wr_u0_vld", 32'(u0_vld), 1);
    check("wr_u0_dout", 32'(u0_dout), 32'hA55A);
    check("wr_u1_vld_early", 32'(u1_vld), 0);
    cen = 1'b1;
    tick;
    check("rd_u0_vld", 32'(u0_vld), 1);
    check("rd_u0_dout", 32'(u0_dout), 32'hA55A);
    check("wr_u1_vld", 32'(u1_vld), 1);
    check("wr_u1_dout", 32'(u1_dout), 32'hA55A);
    tick;
    check("rd_u0_vld_off", 32'(u0_vld), 0);
    check("rd_u1_vld", 32'(u1_vld), 1);
    check("rd_u1_dout", 32'(u1_dout), 32'hA55A);
    tick;
    check("rd_u1_vld_off", 32'(u1_vld), 0);

    // Byte lanes
    xfer("lane_hi", 8'd5, 2'b01, 16'h1234, 16'h125A);
    xfer("lane_lo", 8'd5, 2'b10, 16'hFFCC, 16'h12CC);
    xfer("lane_none", 8'd5, 2'b11, 16'h5555, 16'h12CC);

    // Streaming
    xfer("pre1", 8'd1, 2'b00, 16'h0011, 16'h0011);
    xfer("pre2", 8'd2, 2'b00, 16'h0022, 16'h0022);
    xfer("pre3", 8'd3, 2'b00, 16'h0033, 16'h0033);
    issue(8'd1, 2'b11, 16'h0000);
    issue(8'd2, 2'b11, 16'h0000);
    check("st_u0_d1", 32'(u0_dout), 32'h0011);
    issue(8'd3, 2'b11, 16'h0000);
    check("st_u0_d2", 32'(u0_dout), 32'h0022);
    check("st_u1_v1", 32'(u1_vld), 1);
    check("st_u1_d1", 32'(u1_dout), 32'h0011);
    cen = 1'b1;
    tick;
    check("st_u0_d3", 32'(u0_dout), 32'h0033);
    check("st_u1_v2", 32'(u1_vld), 1);
    check("st_u1_d2", 32'(u1_dout), 32'h0022);
    tick;
    check("st_u0_v_off", 32'(u0_vld), 0);
    check("st_u1_v3", 32'(u1_vld), 1);
    check("st_u1_d3", 32'(u1_dout), 32'h0033);
    tick;
    check("st_u1_v_off", 32'(u1_vld), 0);
    check("st_u1_hold", 32'(u1_dout), 32'h0033);

    // Out of range
    xfer("oor_wr", 8'd200, 2'b00, 16'hFFFF, 16'h0000);
    xfer("oor_rd", 8'd200, 2'b11, 16'h0000, 16'h0000);

    // Streamed sweep of the whole array
    for (int i = 0; i <= 128; i++) begin
      if (i < 128) issue(8'(i), 2'b11, 16'h0000);
      else begin cen = 1'b1; tick; end
      if (i > 0) begin
        check($sformatf("sweep_vld_%0d", i - 1), 32'(u0_vld), 1);
        check($sformatf("sweep_dat_%0d", i - 1), 32'(u0_dout), 32'(exp_word(i - 1)));
      end
    end
    tick;

    // Clear sweep wipes a preloaded word; CLEAR_ON_RESET=0 instance keeps it
    xfer("pre7f", 8'h7F, 2'b00, 16'hBEEF, 16'hBEEF);
    rst = 1'b1;
    tick; tick;
    check("rst2_u0_busy", 32'(u0_busy), 1);
    check("rst2_u2_busy", 32'(u2_busy), 0);
    check("rst2_u0_dout", 32'(u0_dout), 0);
    check("rst2_u1_dout", 32'(u1_dout), 0);
    rst = 1'b0;
    busy_window(n0, n1, vs);
    check("clr_busy_u0", 32'(n0), 128);
    check("clr_busy_u1", 32'(n1), 128);
    issue(8'h7F, 2'b11, 16'h0000);
    cen = 1'b1;
    tick;
    check("clr_u0_vld", 32'(u0_vld), 1);
    check("clr_u0_dout", 32'(u0_dout), 0);
    check("keep_u2_vld", 32'(u2_vld), 1);
    check("keep_u2_dout", 32'(u2_dout), 32'hBEEF);
    tick;
    check("clr_u1_vld", 32'(u1_vld), 1);
    check("clr_u1_dout", 32'(u1_dout), 0);
    tick;

    // Accesses during busy, reset at sweep cycle 50
    blk2 = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    addr = 8'h7F; wen = 2'b00; din = 16'h1111; cen = 1'b0;
    vs = 1'b0;
    tick;
    for (int k = 0; k < 50; k++) begin
      vs = vs | u0_vld | u1_vld;
      tick;
    end
    check("mid_busy_vld", 32'(vs), 0);
    check("mid_busy", 32'(u0_busy), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    busy_window(n0, n1, vs);
    check("mid_rebusy_u0", 32'(n0), 128);
    check("mid_rebusy_u1", 32'(n1), 128);
    check("mid_rebusy_vld", 32'(vs), 0);
    xfer("busy_nowr", 8'h7F, 2'b11, 16'h0000, 16'h0000);
    blk2 = 1'b0;

    // Reset during an in-flight access
    issue(8'd5, 2'b11, 16'h0000);
    cen = 1'b1; rst = 1'b1;
    tick;
    check("inflt_u0_vld", 32'(u0_vld), 0);
    check("inflt_u1_vld", 32'(u1_vld), 0);
    tick;
    check("inflt_u1_vld2", 32'(u1_vld), 0);
    check("inflt_u1_dout", 32'(u1_dout), 0);
    rst = 1'b0;
    busy_window(n0, n1, vs);
    check("final_busy_u0", 32'(n0), 128);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
